// File: rtl/sdram_init_checker.sv
// Passive monitor for the SDRAM power-up sequence: power wait, PRECHARGE ALL, refreshes, then LMR.
// Optional mode-field check at LMR is built with `define SDRAM_INIT_MODE_CHECK_EN.
module sdram_init_checker #(
  parameter int SDRAM_ADDR_WIDTH = 13,
  parameter int tINIT_CYCLE      = 10000,
  parameter int tRP_CYCLE        = 3,
  parameter int tRFC_CYCLE       = 7,
  parameter int tMRD_CYCLE       = 2,
  parameter int INIT_REF_CNT     = 8,
  parameter logic [2:0] EXP_BURST_LENGTH = 3'd0,
  parameter logic [2:0] EXP_CL           = 3'd2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        sdram_cs_n,
  input  logic                        sdram_ras_n,
  input  logic                        sdram_cas_n,
  input  logic                        sdram_we_n,
  input  logic                        sdram_cke,
  input  logic [SDRAM_ADDR_WIDTH-1:0] sdram_addr,
  output logic                        init_ok,
  output logic                        err,
  output logic [2:0]                  err_code,
  output logic [SDRAM_ADDR_WIDTH-1:0] mode_reg,
  output logic [7:0]                  ref_seen
);

  typedef enum logic [2:0] {S_PWR, S_PRE, S_REF, S_DONE, S_ERR} state_t;
  typedef enum logic [2:0] {C_INH, C_NOP, C_PRE, C_REF, C_LMR, C_OTH} cmd_t;

  localparam logic [15:0] TINIT   = 16'(tINIT_CYCLE);
  localparam logic [7:0]  REF_MIN = 8'(INIT_REF_CNT);
  localparam logic [7:0]  RP_LD   = 8'(tRP_CYCLE - 1);
  localparam logic [7:0]  RFC_LD  = 8'(tRFC_CYCLE - 1);
  localparam logic [7:0]  MRD_LD  = 8'(tMRD_CYCLE - 1);

  function automatic cmd_t decode(input logic cs_n, input logic ras_n,
                                  input logic cas_n, input logic we_n);
    if (cs_n) return C_INH;
    case ({ras_n, cas_n, we_n})
      3'b111:  return C_NOP;
      3'b010:  return C_PRE;
      3'b001:  return C_REF;
      3'b000:  return C_LMR;
      default: return C_OTH;
    endcase
  endfunction

  state_t      state;
  cmd_t        cmd;
  logic [15:0] pwr_cnt;
  logic [7:0]  spc_cnt;
  logic        is_cmd;
  logic        f1, f2, f3, f4, f5, f6;
  logic [2:0]  code;

  assign cmd    = decode(sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n);
  assign is_cmd = (cmd != C_INH) && (cmd != C_NOP);

  // Each violation class is evaluated independently; the priority chain picks the lowest code.
  always_comb begin
    f1 = (state == S_PWR) && (cmd == C_PRE) && (pwr_cnt < TINIT);
    f2 = ((state == S_PWR) && (cmd == C_REF || cmd == C_LMR || cmd == C_OTH)) ||
         ((state == S_PRE || state == S_REF) && (cmd == C_OTH)) ||
         ((state == S_PRE) && (cmd == C_LMR)) ||
         ((state == S_REF) && (cmd == C_LMR) && (ref_seen < REF_MIN));
    f3 = (state != S_ERR) && is_cmd && (spc_cnt != 8'd0);
    f4 = (state == S_PWR) && (cmd == C_PRE) && !sdram_addr[10];
`ifdef SDRAM_INIT_MODE_CHECK_EN
    f5 = (state == S_REF) && (cmd == C_LMR) && (ref_seen >= REF_MIN) &&
         ((sdram_addr[2:0] != EXP_BURST_LENGTH) || (sdram_addr[6:4] != EXP_CL));
`else
    f5 = 1'b0;
`endif
    f6 = (state == S_PWR || state == S_PRE || state == S_REF) &&
         !sdram_cke && (pwr_cnt != 16'd0);
    code = 3'd0;
    if      (f1) code = 3'd1;
    else if (f2) code = 3'd2;
    else if (f3) code = 3'd3;
    else if (f4) code = 3'd4;
    else if (f5) code = 3'd5;
    else if (f6) code = 3'd6;
  end

`ifndef SDRAM_INIT_MODE_CHECK_EN
  logic unused_mode_params;
  assign unused_mode_params = ^{EXP_BURST_LENGTH, EXP_CL};
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= S_PWR;
      pwr_cnt  <= 16'd0;
      spc_cnt  <= 8'd0;
      init_ok  <= 1'b0;
      err      <= 1'b0;
      err_code <= 3'd0;
      mode_reg <= '0;
      ref_seen <= 8'd0;
    end else if (code != 3'd0) begin
      state    <= S_ERR;
      err      <= 1'b1;
      err_code <= code;
    end else if (state != S_ERR) begin
      case (cmd)
        C_PRE:   spc_cnt <= RP_LD;
        C_REF:   spc_cnt <= RFC_LD;
        C_LMR:   spc_cnt <= MRD_LD;
        default: if (spc_cnt != 8'd0) spc_cnt <= spc_cnt - 8'd1;
      endcase
      // Reaching here means the command was legal for the current state.
      case (state)
        S_PWR: begin
          if (sdram_cke && pwr_cnt != 16'hFFFF) pwr_cnt <= pwr_cnt + 16'd1;
          if (cmd == C_PRE) state <= S_PRE;
        end
        S_PRE: begin
          if (cmd == C_REF) begin
            state    <= S_REF;
            ref_seen <= 8'd1;
          end
        end
        S_REF: begin
          if (cmd == C_REF && ref_seen != 8'hFF) ref_seen <= ref_seen + 8'd1;
          if (cmd == C_LMR) begin
            mode_reg <= sdram_addr;
            init_ok  <= 1'b1;
            state    <= S_DONE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
